seq_or_monitor: RTL
===================

Name: seq_or_monitor

Overview:
Synthesisable, multi-channel hardware checker for the property "rose(start) |=> (##DLY_A a) or (b ##DLY_B stop)".
- One independent monitor per channel.
- Each monitor reports per-attempt pass/fail pulses, sticky error and overlap flags, and saturating pass/fail counters.
- Sits beside datapath blocks as an on-chip protocol monitor. Results are read by a status/debug block.

Parameters:
NCH, 4, number of independent channels (>=1)
DLY_A, 1, cycles after the |=> cycle at which a must be 1 (>=1)
DLY_B, 2, cycles after the b cycle at which stop must be 1 (>=1)
CNT_W, 8, width of each pass/fail counter (>=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  1 = new attempts may start; 0 = triggers ignored, in-flight attempts complete
clr  in  1  synchronous clear of counters and sticky flags
start  in  NCH  per-channel trigger signal
a  in  NCH  alternative-A operand
b  in  NCH  alternative-B first operand
stop  in  NCH  alternative-B final operand
busy_o  out  NCH  attempt in flight
pass_o  out  NCH  one-cycle pass pulse
fail_o  out  NCH  one-cycle fail pulse
err_o  out  NCH  sticky: any fail since reset/clr
ovl_o  out  NCH  sticky: trigger arrived while busy
pass_cnt  out  NCH*CNT_W  packed saturating pass counters; channel i at [i*CNT_W +: CNT_W]
fail_cnt  out  NCH*CNT_W  packed saturating fail counters

Behaviour:
- Edges are numbered. Trigger at edge t: start[i]=1 and start_q[i]=0. start_q reset value is 0, so start high at the first post-reset edge is a trigger.
- Per-channel FSM IDLE -> BUSY.
  - Age counter k counts from 1 at edge t+1. Width is clog2(max(DLY_A, DLY_B)+2).
- Alternative A matches if a=1 at k=1+DLY_A. It is dead if a=0 there.
- Alternative B:
  - Dead at k=1 if b=0.
  - Otherwise it matches if stop=1 at k=1+DLY_B, and is dead if stop=0 there.
- Resolution happens at the earliest edge where either alternative matches (pass), or where both are dead (fail).
  - Exactly one of pass/fail per attempt.
  - The FSM returns to IDLE at that edge.
- All outputs are registered and reflect the decision at edge t+k. They are visible until the next edge, and pulses last exactly one cycle.
- A trigger at the resolving edge is accepted as a new attempt (back-to-back); it is not an overlap.
- A trigger while BUSY (not the resolving edge) is dropped and sets ovl_o. The running attempt is unaffected.
- A trigger while en=0 is ignored silently: no ovl_o and no attempt. start_q still updates.
- Counters:
  - Increment by 1 on a pass/fail pulse.
  - Saturate at 2^CNT_W-1.
  - err_o is set on any fail pulse.
- clr:
  - Zeroes counters, err_o and ovl_o. If clr coincides with an increment or set, clr wins.
  - Does not abort attempts and does not affect busy/pulse outputs.
- Reset values (rst_n=0 at an edge), regardless of state: all outputs 0, FSMs IDLE, start_q 0. In-flight attempts are discarded without reporting.
- Channels are fully independent; no cross-channel interaction.

Decomposition:
- Package seq_or_monitor_pkg: FSM state enum (IDLE, BUSY); function computing the age width from DLY_A/DLY_B; saturating-increment function.
- Sub-module seq_or_chan: one channel with FSM, age counter, flags and counters. It is instantiated NCH times by a generate loop in the top.

Test Plan:
- Defaults, ch0: trigger at edge 2, b=0 at edge 3, a=1 at edge 4 -> pass_o[0] for one cycle after edge 4, pass_cnt ch0=1, busy_o[0] low after edge 4.
- Alternative B: trigger at edge t, b=1 at t+1, a=0 at t+2, stop=1 at t+3 -> pass after t+3, fail_cnt unchanged.
- Early fail: trigger at t, b=0 at t+1, a=0 at t+2 -> fail after t+2, err_o=1. Second case: b=1, a=0, stop=0 -> fail after t+3.
- Overlap and back-to-back:
  - Trigger at t, start low at t+1, trigger at t+2 -> ovl_o=1, exactly one result.
  - Trigger exactly at the resolving edge -> new attempt starts, ovl_o stays 0.
- Saturation and clr: CNT_W=2 with 5 passes -> pass_cnt=3. clr on the same edge as a pass -> pass_cnt=0, err_o=0.
- Reset and en:
  - rst_n=0 at t+1 mid-attempt -> no pulse, all outputs 0.
  - en=0 trigger -> no attempt, busy_o stays 0.
  - Concurrent ch0 pass and ch3 fail are reported independently.

Source files
------------

// File: rtl/seq_or_monitor_pkg.sv
// Shared types and helpers for the seq_or_monitor protocol checker.
package seq_or_monitor_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } chan_state_e;

  // Age counter width: must hold ages up to 1 + max(DLY_A, DLY_B).
  function automatic int age_width(input int dly_a, input int dly_b);
    int m;
    m = (dly_a > dly_b) ? dly_a : dly_b;
    return $clog2(m + 2);
  endfunction

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (val >= max_v) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage

// File: rtl/seq_or_chan.sv
// One monitor channel for "rose(start) |=> (##DLY_A a) or (b ##DLY_B stop)".
module seq_or_chan
  import seq_or_monitor_pkg::*;
#(
  parameter int DLY_A = 1,
  parameter int DLY_B = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             stop,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             err_o,
  output logic             ovl_o,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int AGE_W = age_width(DLY_A, DLY_B);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_A   = AGE_W'(1 + DLY_A);
  localparam logic [AGE_W-1:0] AGE_B   = AGE_W'(1 + DLY_B);

  chan_state_e      state_r;
  logic [AGE_W-1:0] age_r;
  logic             a_dead_r;
  logic             b_dead_r;
  logic             start_q_r;

  logic trig_s;
  logic a_match_s;
  logic a_dead_s;
  logic b_early_dead_s;
  logic b_match_s;
  logic b_dead_s;
  logic pass_s;
  logic fail_s;
  logic resolve_s;
  logic accept_s;
  logic ovl_set_s;

  // Evaluate both alternatives at the current age and decide pass/fail/accept.
  always_comb begin
    trig_s         = start & ~start_q_r & en;
    a_match_s      = 1'b0;
    a_dead_s       = 1'b0;
    b_early_dead_s = 1'b0;
    b_match_s      = 1'b0;
    b_dead_s       = 1'b0;
    if (state_r == BUSY) begin
      a_match_s      = (age_r == AGE_A) & a;
      a_dead_s       = a_dead_r | ((age_r == AGE_A) & ~a);
      // b is only sampled at the first age; once dead it stays dead.
      b_early_dead_s = b_dead_r | ((age_r == AGE_ONE) & ~b);
      b_match_s      = ~b_early_dead_s & (age_r == AGE_B) & stop;
      b_dead_s       = b_early_dead_s | ((age_r == AGE_B) & ~stop);
    end else begin
      a_match_s      = 1'b0;
    end
    pass_s    = a_match_s | b_match_s;
    fail_s    = ~pass_s & a_dead_s & b_dead_s;
    resolve_s = pass_s | fail_s;
    // A trigger on the resolving edge starts the next attempt back-to-back.
    accept_s  = trig_s & ((state_r == IDLE) | resolve_s);
    ovl_set_s = trig_s & (state_r == BUSY) & ~resolve_s;
  end

  // Channel FSM, age tracking, result pulses, sticky flags and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      age_r     <= '0;
      a_dead_r  <= 1'b0;
      b_dead_r  <= 1'b0;
      start_q_r <= 1'b0;
      busy_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      err_o     <= 1'b0;
      ovl_o     <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      start_q_r <= start;
      pass_o    <= pass_s;
      fail_o    <= fail_s;

      if (accept_s) begin
        state_r  <= BUSY;
        age_r    <= AGE_ONE;
        a_dead_r <= 1'b0;
        b_dead_r <= 1'b0;
        busy_o   <= 1'b1;
      end else if (resolve_s) begin
        state_r  <= IDLE;
        age_r    <= '0;
        a_dead_r <= 1'b0;
        b_dead_r <= 1'b0;
        busy_o   <= 1'b0;
      end else if (state_r == BUSY) begin
        age_r    <= age_r + AGE_ONE;
        a_dead_r <= a_dead_s;
        b_dead_r <= b_dead_s;
        busy_o   <= 1'b1;
      end else begin
        busy_o   <= 1'b0;
      end

      // clr has priority over any increment or flag set on the same edge.
      if (clr) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        err_o    <= 1'b0;
        ovl_o    <= 1'b0;
      end else begin
        if (pass_s) begin
          pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_W));
        end
        if (fail_s) begin
          fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
        end
        err_o <= err_o | fail_s;
        ovl_o <= ovl_o | ovl_set_s;
      end
    end
  end

endmodule

// File: rtl/seq_or_monitor.sv
// Multi-channel wrapper: NCH independent seq_or_chan monitors.
module seq_or_monitor
  import seq_or_monitor_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DLY_A = 1,
  parameter int DLY_B = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  input  logic [NCH-1:0]       stop,
  output logic [NCH-1:0]       busy_o,
  output logic [NCH-1:0]       pass_o,
  output logic [NCH-1:0]       fail_o,
  output logic [NCH-1:0]       err_o,
  output logic [NCH-1:0]       ovl_o,
  output logic [NCH*CNT_W-1:0] pass_cnt,
  output logic [NCH*CNT_W-1:0] fail_cnt
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    seq_or_chan #(
      .DLY_A (DLY_A),
      .DLY_B (DLY_B),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .start    (start[i]),
      .a        (a[i]),
      .b        (b[i]),
      .stop     (stop[i]),
      .busy_o   (busy_o[i]),
      .pass_o   (pass_o[i]),
      .fail_o   (fail_o[i]),
      .err_o    (err_o[i]),
      .ovl_o    (ovl_o[i]),
      .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule
